stream_arb_4_1: RTL and testbench

Four-input stream arbiter that feeds a single 4:1 datapath from four valid/ready producers. Each cycle it picks one requesting source by round-robin, forwards that source's data and 2-bit source index into a one-entry registered output stage, and back-pressures all other sources. It sits directly upstream of the 4:1 mux stage and turns its static select into an arbitrated, flow-controlled stream.

---
 rtl/stream_arb_pkg.sv | 6 +
 rtl/rr_arbiter_4.sv | 45 ++++
 rtl/stream_arb_4_1.sv | 103 ++++++++++
 tb/tb_stream_arb_4_1.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and constants for the 4:1 stream arbiter
package stream_arb_pkg;
  localparam int N_SRC = 4;
  typedef logic [1:0] src_idx_t;
  typedef logic [3:0] src_mask_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way round-robin grant search from ptr
// STREAM_ARB_FIXED_PRIO_EN selects fixed priority (source 0 highest) and ignores ptr.
module rr_arbiter_4
  import stream_arb_pkg::*;
(
  input  src_mask_t req,
  input  src_idx_t  ptr,
  output src_mask_t grant,
  output src_idx_t  grant_idx,
  output logic      any
);

`ifdef STREAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant_idx = '0;
    // Descending scan so the lowest-index requester is the last write and wins.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req[k]) grant_idx = src_idx_t'(k);
    end
  end
`else
  src_idx_t cand;
  logic     found;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = ptr + src_idx_t'(k);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end
`endif

  assign any   = |req;
  assign grant = any ? (src_mask_t'(1) << grant_idx) : '0;

endmodule

// File: rtl/stream_arb_4_1.sv
// rtl/stream_arb_4_1.sv - four-source valid/ready arbiter feeding a one-entry output register
// STREAM_ARB_FIXED_PRIO_EN removes the round-robin pointer (fixed priority, source 0 first).
module stream_arb_4_1
  import stream_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  src_idx_t         out_sel_q, out_sel_d;
  src_idx_t         ptr;
  src_mask_t        grant;
  src_idx_t         grant_idx;
  logic             any;
  logic             load_en;
  logic [WIDTH-1:0] grant_data;

  rr_arbiter_4 u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_comb begin
    grant_data = d0;
    case (grant_idx)
      2'd0:    grant_data = d0;
      2'd1:    grant_data = d1;
      2'd2:    grant_data = d2;
      default: grant_data = d3;
    endcase
  end

  // Register is free when empty or when its word drains this same cycle.
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = (load_en && any && !rst) ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      if (any) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_sel_d   = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

`ifdef STREAM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  src_idx_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_en && any) ptr_d = grant_idx + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_4_1.sv
// tb/tb_stream_arb_4_1.sv - randomized and directed self-checking bench for stream_arb_4_1
module tb_stream_arb_4_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid = 4'h0;
  logic [3:0] in_ready;
  logic [3:0] d0 = 4'h0, d1 = 4'h0, d2 = 4'h0, d3 = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  int errors = 0;
  int checks = 0;

  // Reference model state: the word the output register should hold and the next search start.
  logic       m_valid = 1'b0;
  logic [3:0] m_data  = 4'h0;
  int         m_sel   = 0;
  int         m_ptr   = 0;

  stream_arb_4_1 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant(input logic [3:0] req, input int ptr);
    int start;
`ifdef STREAM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (req[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] pick(input int g);
    case (g)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant(in_valid, m_ptr);
    if (rst || (m_valid && !out_ready) || g < 0) return 4'h0;
    return 4'h1 << g;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 4'h0;
    m_sel   = 0;
    m_ptr   = 0;
  endfunction

  function automatic void model_update();
    int g;
    if (rst) begin
      model_reset();
    end else if (!m_valid || out_ready) begin
      g = exp_grant(in_valid, m_ptr);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = pick(g);
        m_sel   = g;
        m_ptr   = (g + 1) % 4;
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    rst = 1'b1;
    step();
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready got=%h want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got=%0d want=0", out_sel); end
    rst = 1'b0;
    in_valid = 4'h0;
    step();
  endtask

  task automatic test_single_source();
    in_valid = 4'b0100; d2 = 4'hC; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got=%b want=0100", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 4'hC || out_sel !== 2'd2) begin
      errors++; $display("FAIL single_out got=%b/%h/%0d want=1/c/2", out_valid, out_data, out_sel);
    end
    // Pointer should now start the search at source 3.
    in_valid = 4'hF;
    #1;
`ifdef STREAM_ARB_FIXED_PRIO_EN
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL single_next_ready got=%b want=0001", in_ready); end
`else
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL single_next_ready got=%b want=1000", in_ready); end
`endif
    step();
    in_valid = 4'h0;
    step();
  endtask

  task automatic test_contention();
    int want;
    pulse_reset();
    in_valid = 4'hF; out_ready = 1'b1;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL contend_ready[%0d] got=%b want=%b", i, in_ready, exp_ready()); end
      step();
`ifdef STREAM_ARB_FIXED_PRIO_EN
      want = 0;
`else
      want = i % 4;
`endif
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'(want) || out_data !== 4'(10 + want)) begin
        errors++; $display("FAIL contend_out[%0d] got=%b/%0d/%h want=1/%0d/%h", i, out_valid, out_sel, out_data, want, 4'(10 + want));
      end
    end
    in_valid = 4'h0;
    step();
  endtask

  task automatic test_back_pressure();
    in_valid = 4'b0001; d0 = 4'h7; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      d0 = 4'($urandom_range(0, 15));
      #1;
      checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0000", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 4'h7) begin
        errors++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/7", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== exp_ready() || in_ready === 4'h0) begin errors++; $display("FAIL bp_release_ready got=%b want=%b", in_ready, exp_ready()); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== m_data || out_sel !== 2'(m_sel)) begin
      errors++; $display("FAIL bp_release_out got=%b/%h/%0d want=1/%h/%0d", out_valid, out_data, out_sel, m_data, m_sel);
    end
    in_valid = 4'h0;
    step();
  endtask

  task automatic test_skip_idle();
    pulse_reset();
    out_ready = 1'b1;
    in_valid = 4'b0001; d0 = 4'h5;
    step();
    in_valid = 4'b0001; d0 = 4'h6;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL skip_wrap_ready got=%b want=0001", in_ready); end
    step();
    checks++; if (out_sel !== 2'd0 || out_data !== 4'h6) begin errors++; $display("FAIL skip_wrap_out got=%0d/%h want=0/6", out_sel, out_data); end
    in_valid = 4'b1001; d3 = 4'h9;
    #1;
`ifdef STREAM_ARB_FIXED_PRIO_EN
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL skip_pick_ready got=%b want=0001", in_ready); end
`else
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL skip_pick_ready got=%b want=1000", in_ready); end
`endif
    step();
    checks++; if (out_sel !== 2'(m_sel) || out_data !== m_data) begin errors++; $display("FAIL skip_pick_out got=%0d/%h want=%0d/%h", out_sel, out_data, m_sel, m_data); end
    in_valid = 4'h0;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== m_data) begin errors++; $display("FAIL idle_drain got=%b/%h want=0/%h", out_valid, out_data, m_data); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 4'b0010; d1 = 4'hE;
    step();
    in_valid = 4'hF;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 4'h0) begin
      errors++; $display("FAIL mid_reset got=%b/%h/%b want=0/0/0000", out_valid, out_data, in_ready);
    end
    model_reset();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_reset_first_grant got=%b want=0001", in_ready); end
    step();
    in_valid = 4'h0;
    step();
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [3:0] acc;
    int         bad_rdy;
    int         bad_out;
    pend = 4'h0;
    bad_rdy = 0;
    bad_out = 0;
    for (int i = 0; i < 400; i++) begin
      // Producers hold a request and its data until accepted.
      for (int s = 0; s < 4; s++) begin
        if (!pend[s] && ($urandom_range(0, 1) == 1)) begin
          pend[s] = 1'b1;
          case (s)
            0: d0 = 4'($urandom_range(0, 15));
            1: d1 = 4'($urandom_range(0, 15));
            2: d2 = 4'($urandom_range(0, 15));
            default: d3 = 4'($urandom_range(0, 15));
          endcase
        end
      end
      in_valid  = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = exp_ready();
      checks++; if (in_ready !== acc) begin
        errors++; bad_rdy++;
        if (bad_rdy < 5) $display("FAIL rand_ready[%0d] got=%b want=%b", i, in_ready, acc);
      end
      step();
      pend = pend & ~acc;
      checks++; if (out_valid !== m_valid || out_data !== m_data || out_sel !== 2'(m_sel)) begin
        errors++; bad_out++;
        if (bad_out < 5) $display("FAIL rand_out[%0d] got=%b/%h/%0d want=%b/%h/%0d", i, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    in_valid = 4'h0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_back_pressure();
    test_skip_idle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
